// File: rtl/cpu_pkg.sv
// Shared types and defaults for the fetch front end of the 32-bit MIPS pipeline.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  // ISSUE: request on the bus; WAIT: one read outstanding; HOLD: response parked in skid.
  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
  } if_id_t;

  // Sequential successor address; wraps modulo 2^32.
  function automatic logic [31:0] seq_pc(input logic [31:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/if_skid_reg.sv
// One-entry {valid, instr, pc4} holding register with load and clear; used as IF/ID and as skid.
// Latency: one cycle from load_i to dat_o.
// Backpressure: none internally; the owner decides when to load or clear.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load_i       capture dat_i (wins over clr_i)
//   clr_i        drop the entry: valid=0, instr=CLR_INSTR, pc4 kept
//   dat_i        entry to capture
//   dat_o        held entry; dat_o.valid doubles as the not-empty flag
module if_skid_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] CLR_INSTR = NOP_INSTR_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load_i,
  input  logic   clr_i,
  input  if_id_t dat_i,
  output if_id_t dat_o
);

  if_id_t ent_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q <= '{valid: 1'b0, instr: CLR_INSTR, pc4: 32'h0};
    end else if (load_i) begin
      ent_q <= dat_i;
    end else if (clr_i) begin
      ent_q.valid <= 1'b0;
      ent_q.instr <= CLR_INSTR;
    end
  end

  assign dat_o = ent_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// PC register and instruction fetch: one imem read at a time, delivers {instr, pc+4} via IF/ID.
// Latency: zero-wait memory gives req at N, rvalid at N+1, if_valid at N+2 (1 instr / 2 cycles).
// Backpressure: stall holds IF/ID; a response arriving while IF/ID is held parks in a skid entry.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   next_pc, redirect                jump/taken-branch target and its strobe (highest priority)
//   stall                            hazard unit holds IF/ID
//   pc, pc4                          current fetch address and pc+4 (combinational)
//   imem_req/addr/ready              read request handshake (address = pc)
//   imem_rvalid/rdata                read response, one per accepted request
//   if_valid, if_instr, if_pc4       IF/ID register contents
module pc_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4
);

  fetch_state_e state_q, state_d;
  logic         kill_q, kill_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_plus4;

  if_id_t ifid_q, skid_q, rsp_ent, ifid_din;
  logic   ifid_load, ifid_clr, skid_load, skid_clr;
  logic   accept, consume;

  assign pc_plus4 = seq_pc(pc_q);
  assign accept   = imem_req && imem_ready;
  assign consume  = ifid_q.valid && !stall;
  assign rsp_ent  = '{valid: 1'b1, instr: imem_rdata, pc4: pc_plus4};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ISSUE;
      kill_q  <= 1'b0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    pc_d      = pc_q;
    ifid_load = 1'b0;
    ifid_clr  = consume;
    ifid_din  = rsp_ent;
    skid_load = 1'b0;
    skid_clr  = 1'b0;

    if (redirect) begin
      // Flush everything buffered; a read already in flight must be discarded on return.
      pc_d     = next_pc;
      ifid_clr = 1'b1;
      skid_clr = 1'b1;
      case (state_q)
        ISSUE: begin
          if (accept) begin
            state_d = WAIT;
            kill_d  = 1'b1;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state_d = ISSUE;
            kill_d  = 1'b0;
          end else begin
            kill_d = 1'b1;
          end
        end
        default: begin
          state_d = ISSUE;
          kill_d  = 1'b0;
        end
      endcase
    end else begin
      case (state_q)
        ISSUE: begin
          // rvalid here can only be a leftover from before reset; ignore it.
          if (accept) state_d = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = ISSUE;
            end else if (!ifid_q.valid || consume) begin
              ifid_load = 1'b1;
              pc_d      = pc_plus4;
              state_d   = ISSUE;
            end else begin
              // pc stays put until the parked word actually enters IF/ID.
              skid_load = 1'b1;
              state_d   = HOLD;
            end
          end
        end
        HOLD: begin
          if (consume && skid_q.valid) begin
            ifid_load = 1'b1;
            ifid_din  = skid_q;
            skid_clr  = 1'b1;
            pc_d      = pc_plus4;
            state_d   = ISSUE;
          end
        end
        default: begin
          state_d = ISSUE;
          kill_d  = 1'b0;
        end
      endcase
    end
  end

  if_skid_reg #(.CLR_INSTR(NOP_INSTR)) u_ifid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (ifid_load),
    .clr_i  (ifid_clr),
    .dat_i  (ifid_din),
    .dat_o  (ifid_q)
  );

  if_skid_reg #(.CLR_INSTR(NOP_INSTR)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (skid_load),
    .clr_i  (skid_clr),
    .dat_i  (rsp_ent),
    .dat_o  (skid_q)
  );

  assign pc        = pc_q;
  assign pc4       = pc_plus4;
  assign imem_req  = (state_q == ISSUE);
  assign imem_addr = pc_q;
  assign if_valid  = ifid_q.valid;
  assign if_instr  = ifid_q.instr;
  assign if_pc4    = ifid_q.pc4;

endmodule
